// File: rtl/gio_pkg.sv
// Shared op codes and constants for the gio output bank.
// Readback is compiled in only when GIO_READBACK_EN is defined (see gio_outbank).
package gio_pkg;

  typedef enum logic [1:0] {
    OP_DATA  = 2'd0,
    OP_SET   = 2'd1,
    OP_CLR   = 2'd2,
    OP_PULSE = 2'd3
  } gio_op_e;

  localparam int         GIO_STRIDE  = 4;
  localparam logic [7:0] GIO_RST_VAL = 8'h00;

endpackage

// File: rtl/gio_channel.sv
// One output channel: a persistent data register plus a self-clearing pulse
// overlay whose lifetime is reloaded by every pulse write.
module gio_channel
  import gio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CW        = 8,
  parameter int PULSE_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  gio_op_e          op,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic [WIDTH-1:0] data_q,
  output logic [WIDTH-1:0] pulse_q,
  output logic [CW-1:0]    cnt_q
);

  localparam logic [WIDTH-1:0] RST_W    = GIO_RST_VAL[WIDTH-1:0];
  localparam logic [CW-1:0]    CNT_LOAD = CW'(PULSE_LEN - 1);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] pulse_reg;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_reg  <= RST_W;
      pulse_reg <= RST_W;
      cnt       <= '0;
    end else begin
      if (we) begin
        case (op)
          OP_DATA:  data_reg <= val;
          OP_SET:   data_reg <= data_reg | val;
          OP_CLR:   data_reg <= data_reg & ~val;
          OP_PULSE: begin
            pulse_reg <= pulse_reg | val;
            cnt       <= CNT_LOAD;
          end
          default: ;
        endcase
      end
      // A pulse write in this cycle takes priority over the countdown.
      if (!(we && op == OP_PULSE) && pulse_reg != '0) begin
        if (cnt != '0) cnt <= cnt - CW'(1);
        else           pulse_reg <= '0;
      end
    end
  end

  assign out     = data_reg | pulse_reg;
  assign busy    = |pulse_reg;
  assign data_q  = data_reg;
  assign pulse_q = pulse_reg;
  assign cnt_q   = cnt;

endmodule

// File: rtl/gio_outbank.sv
// Bank of NCH output channels decoded from a 4*NCH address window at BASE_ADDR.
// Define GIO_READBACK_EN to add the registered data_out readback path.
module gio_outbank
  import gio_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h01,
  parameter int         NCH       = 4,
  parameter int         WIDTH     = 8,
  parameter int         PULSE_LEN = 4,
  parameter int         CW        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           address,
  input  logic [7:0]           value_in,
  input  logic                 wen,
  input  logic                 ren,
  output logic [NCH*WIDTH-1:0] port_out,
  output logic [NCH-1:0]       pulse_busy,
  output logic [WIDTH-1:0]     data_out,
  output logic                 hit
);

  localparam int WIN = GIO_STRIDE * NCH;

  logic [7:0] off;
  logic [5:0] ch_sel;
  gio_op_e    op;
  logic       wr_en;

  // Window can reach 256 entries, so compare in 9 bits.
  assign off    = address - BASE_ADDR;
  assign hit    = (address >= BASE_ADDR) && ({1'b0, off} < 9'(WIN));
  assign ch_sel = off[7:2];
  assign op     = gio_op_e'(off[1:0]);
  assign wr_en  = wen && hit;

  logic [NCH-1:0][WIDTH-1:0] ch_out;
  logic [NCH-1:0][WIDTH-1:0] ch_data;
  logic [NCH-1:0][WIDTH-1:0] ch_pulse;
  logic [NCH-1:0][CW-1:0]    ch_cnt;
  logic [NCH-1:0]            ch_busy;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    gio_channel #(
      .WIDTH    (WIDTH),
      .CW       (CW),
      .PULSE_LEN(PULSE_LEN)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .we     (wr_en && ch_sel == 6'(g)),
      .op     (op),
      .val    (value_in[WIDTH-1:0]),
      .out    (ch_out[g]),
      .busy   (ch_busy[g]),
      .data_q (ch_data[g]),
      .pulse_q(ch_pulse[g]),
      .cnt_q  (ch_cnt[g])
    );
  end

  assign port_out   = ch_out;
  assign pulse_busy = ch_busy;

`ifdef GIO_READBACK_EN
  logic [WIDTH-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel == 6'(i)) begin
        case (op)
          OP_DATA:  rd_val = ch_data[i];
          OP_SET:   rd_val = ch_out[i];
          OP_CLR:   rd_val = ch_pulse[i];
          OP_PULSE: rd_val = WIDTH'(ch_cnt[i]);
          default:  rd_val = '0;
        endcase
      end
    end
  end

  // Reads sample pre-write state, so a same-cycle write is not visible.
  always_ff @(posedge clk) begin
    if (!rst)     data_out <= '0;
    else if (ren) data_out <= hit ? rd_val : '0;
  end

  logic unused_ok;
  assign unused_ok = ^{value_in};
`else
  assign data_out = '0;

  logic unused_ok;
  assign unused_ok = ^{ren, value_in, ch_data, ch_pulse, ch_cnt};
`endif

endmodule

// File: doc/gio_outbank.md
Name: gio_outbank

Overview:
- Parametrised successor to the single-address output port: a bank of NCH output registers, WIDTH bits each, decoded from a contiguous address window starting at BASE_ADDR on the processor I/O bus.
- Each channel supports four write operations: replace, bit-set, bit-clear and timed pulse. A pulse auto-clears after PULSE_LEN cycles.
- Sits between the processor's port-write strobe and board-level GPIO/control lines.

Parameters:
- BASE_ADDR, 8'h01, first address of the window; window length is 4*NCH; BASE_ADDR+4*NCH must be <= 256.
- NCH, 4, number of output channels (>=1).
- WIDTH, 8, bits per channel (1..8; value_in upper bits ignored when WIDTH<8).
- PULSE_LEN, 4, pulse duration in clk cycles (>=1).
- CW, 8, pulse counter width; PULSE_LEN must be < 2**CW.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-low reset.
- address  input  8  I/O port address.
- value_in  input  8  write data.
- wen  input  1  write strobe, one-cycle qualified.
- ren  input  1  read strobe (used only with readback feature).
- port_out  output  NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]; registered.
- pulse_busy  output  NCH  bit i high while channel i pulse active.
- data_out  output  WIDTH  readback data.
- hit  output  1  combinational: address inside window.

Behaviour:
- Decode: off = address - BASE_ADDR; hit = (address >= BASE_ADDR) && (off < 4*NCH); ch = off[7:2]; op = off[1:0].
- Per channel state: data_reg[WIDTH], pulse_reg[WIDTH], cnt[CW].
- port_out[ch] = data_reg | pulse_reg, driven from registers only (no combinational path from inputs).
- pulse_busy[ch] = (pulse_reg != 0).
- Reset (rst==0 at edge): all data_reg, pulse_reg, cnt, data_out = 0. Reset overrides any wen/ren in the same cycle and kills an in-flight pulse immediately.
- Writes: effective at the edge where wen=1 && hit. Result is visible on port_out the following cycle (1-cycle latency). wen with !hit: no state change.
  - op0 replace: data_reg <= value_in.
  - op1 set: data_reg <= data_reg | value_in.
  - op2 clear: data_reg <= data_reg & ~value_in.
  - op3 pulse: pulse_reg <= pulse_reg | value_in; cnt <= PULSE_LEN-1.
- Pulse timing: bits stay asserted for exactly PULSE_LEN cycles. Each cycle with pulse_reg!=0 and no op3 write to that channel:
  - cnt != 0: cnt decrements.
  - cnt == 0: pulse_reg <= 0.
- Retrigger: an op3 write while busy ORs in the new bits and reloads cnt, so all bits extend to PULSE_LEN from the new write.
- op3 with value_in==0 while idle: cnt loads, pulse_reg stays 0, no visible effect.
- Data vs pulse independence: op0-op2 never touch pulse_reg or cnt. A pulse bit already high in data_reg shows no visible change.
- Channel isolation: a write to channel i affects only channel i. Other channels' pulse counters keep running.
- Only one write per cycle is possible (single bus).

Optional Feature:
- Macro GIO_READBACK_EN.
- Defined: on an edge with ren=1 && hit, data_out <= the following, selected by op:
  - op0: data_reg[ch]
  - op1: port_out[ch]
  - op2: pulse_reg[ch]
  - op3: cnt[ch], zero-extended or truncated to WIDTH
- Defined, timing: 1-cycle read latency. ren with !hit sets data_out <= 0. If wen and ren target the same channel in one cycle, the read returns pre-write values.
- Undefined: data_out tied to 0; ren ignored; no read registers synthesised.

Decomposition:
- Shared package/header gio_pkg holds:
  - op codes: OP_DATA=0, OP_SET=1, OP_CLR=2, OP_PULSE=3
  - window stride constant GIO_STRIDE=4
  - reset value constant GIO_RST_VAL=0
- One sub-module, gio_channel: per-channel data_reg/pulse_reg/cnt. Inputs are a per-channel write enable, op and value; outputs are out, busy and the readback fields.
- Top-level gio_outbank does decode, generate-instantiates NCH channels and handles the readback mux.

Test Plan:
- Reset: drive garbage writes, rst=0 for 2 cycles -> port_out=0, pulse_busy=0, data_out=0; a wen during reset has no effect.
- Replace/set/clear, defaults (BASE 01, NCH 4):
  - write 0x01=AA -> ch0=AA next cycle
  - write 0x02=05 -> AF
  - write 0x03=0F -> A0
  - ch1..3 remain 00
- Decode boundaries:
  - write 0x00=FF and 0x11=FF -> no change, hit=0
  - write 0x10=05 (ch3 op3) -> ch3 pulses 05
  - write 0x0D=3C -> ch3 data=3C
- Pulse timing, PULSE_LEN=4:
  - write 0x04=81 -> ch0 bits 81 set for exactly 4 cycles, then port_out=data_reg
  - retrigger at cycle 2 with 02 -> 83 held 4 more cycles from the retrigger
- Reset mid-pulse: start pulse, assert rst at cycle 2 -> all outputs 0 next cycle; no residual pulse after rst releases.
- With GIO_READBACK_EN:
  - write 0x05=3C, ren at 0x05 -> data_out=3C after 1 cycle
  - ren at 0x08 during pulse -> remaining cnt
  - ren at 0x20 -> 00
